// File: rtl/sram_bus_arbiter_pkg.sv
// Shared encodings and phase-timer helpers for the SRAM bus arbiter.
package sram_bus_arbiter_pkg;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_SETUP  = 2'd1,
        ST_STROBE = 2'd2,
        ST_HOLD   = 2'd3
    } arbState_e;

    typedef enum logic {
        OWN_CPU = 1'b0,
        OWN_ICD = 1'b1
    } arbOwner_e;

    localparam int PHASE_W = 3;

    // The timer counts down to zero, so a phase lasting N cycles loads N-1.
    function automatic logic [PHASE_W-1:0] phaseLoad(input int cycles);
        return PHASE_W'(cycles - 1);
    endfunction

endpackage

// File: rtl/sram_bus_arbiter_timer.sv
// Loadable down-counter that times one bus phase; done is high in the phase's last cycle.
module arb_phase_timer
    import sram_bus_arbiter_pkg::*;
(
    input  logic               clk_i,
    input  logic               rst_n_i,
    input  logic               load_i,
    input  logic [PHASE_W-1:0] loadVal_i,
    output logic               done_o
);

    logic [PHASE_W-1:0] count_q;

    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            count_q <= '0;
        end else if (load_i) begin
            count_q <= loadVal_i;
        end else if (count_q != '0) begin
            count_q <= count_q - 1'b1;
        end
    end

    assign done_o = (count_q == '0);

endmodule

// File: rtl/sram_bus_arbiter.sv
// Shares the external SRAM bus between the CPU (fixed priority) and the ICD/debug DMA path,
// sequencing each access as SETUP -> STROBE -> HOLD with registered pin outputs.
module sram_bus_arbiter
    import sram_bus_arbiter_pkg::*;
#(
    parameter int ADDR_W     = 21,
    parameter int SETUP_CYC  = 1,
    parameter int STROBE_CYC = 2,
    parameter int HOLD_CYC   = 1
) (
    input  logic              clk6x,
    input  logic              resetn,
    input  logic              cpu_req,
    input  logic              cpu_wr,
    input  logic [ADDR_W-1:0] cpu_addr,
    input  logic [7:0]        cpu_wdata,
    output logic [7:0]        cpu_rdata,
    output logic              cpu_ack,
    input  logic              cpu_slot_soon,
    input  logic              icd_req,
    input  logic              icd_wr,
    input  logic [ADDR_W-1:0] icd_addr,
    input  logic [7:0]        icd_wdata,
    output logic [7:0]        icd_rdata,
    output logic              icd_ack,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [7:0]        mem_wdata,
    output logic              mem_wdata_oe,
    input  logic [7:0]        mem_rdata,
    output logic              m1cs_n,
    output logic              mrd_n,
    output logic              mwr_n
);

    arbState_e          state_q;
    arbOwner_e          owner_q;
    logic               wr_q;
    logic [ADDR_W-1:0]  memAddr_q;
    logic [7:0]         memWdata_q;
    logic [7:0]         cpuRdata_q;
    logic [7:0]         icdRdata_q;
    logic               m1csN_q;
    logic               mrdN_q;
    logic               mwrN_q;
    logic               wdataOe_q;
    logic               cpuAck_q;
    logic               icdAck_q;

    logic               grantCpu_d;
    logic               grantIcd_d;
    logic               reqWr_d;
    logic [ADDR_W-1:0]  reqAddr_d;
    logic [7:0]         reqWdata_d;
    logic               timerLoad_d;
    logic [PHASE_W-1:0] timerLoadVal_d;
    logic               phaseDone;

    // The ICD only gets a slot when the CPU is idle and its next slot is not imminent.
    always_comb begin
        grantCpu_d     = 1'b0;
        grantIcd_d     = 1'b0;
        timerLoad_d    = 1'b0;
        timerLoadVal_d = '0;
        case (state_q)
            ST_IDLE: begin
                grantCpu_d     = cpu_req;
                grantIcd_d     = !cpu_req && icd_req && !cpu_slot_soon;
                timerLoad_d    = grantCpu_d || grantIcd_d;
                timerLoadVal_d = phaseLoad(SETUP_CYC);
            end
            ST_SETUP: begin
                timerLoad_d    = phaseDone;
                timerLoadVal_d = phaseLoad(STROBE_CYC);
            end
            ST_STROBE: begin
                timerLoad_d    = phaseDone;
                timerLoadVal_d = phaseLoad(HOLD_CYC);
            end
            default: begin
                timerLoad_d    = 1'b0;
            end
        endcase
        reqWr_d    = grantCpu_d ? cpu_wr    : icd_wr;
        reqAddr_d  = grantCpu_d ? cpu_addr  : icd_addr;
        reqWdata_d = grantCpu_d ? cpu_wdata : icd_wdata;
    end

    arb_phase_timer uPhaseTimer (
        .clk_i     (clk6x),
        .rst_n_i   (resetn),
        .load_i    (timerLoad_d),
        .loadVal_i (timerLoadVal_d),
        .done_o    (phaseDone)
    );

    always_ff @(posedge clk6x or negedge resetn) begin
        if (!resetn) begin
            state_q    <= ST_IDLE;
            owner_q    <= OWN_CPU;
            wr_q       <= 1'b0;
            memAddr_q  <= '0;
            memWdata_q <= '0;
            cpuRdata_q <= '0;
            icdRdata_q <= '0;
            m1csN_q    <= 1'b1;
            mrdN_q     <= 1'b1;
            mwrN_q     <= 1'b1;
            wdataOe_q  <= 1'b0;
            cpuAck_q   <= 1'b0;
            icdAck_q   <= 1'b0;
        end else begin
            cpuAck_q <= 1'b0;
            icdAck_q <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (grantCpu_d || grantIcd_d) begin
                        state_q    <= ST_SETUP;
                        owner_q    <= grantCpu_d ? OWN_CPU : OWN_ICD;
                        wr_q       <= reqWr_d;
                        memAddr_q  <= reqAddr_d;
                        memWdata_q <= reqWdata_d;
                        m1csN_q    <= 1'b0;
                        wdataOe_q  <= reqWr_d;
                    end
                end
                ST_SETUP: begin
                    if (phaseDone) begin
                        state_q <= ST_STROBE;
                        mrdN_q  <= wr_q;
                        mwrN_q  <= !wr_q;
                    end
                end
                ST_STROBE: begin
                    // Read data is sampled on the edge that closes the strobe window.
                    if (phaseDone) begin
                        state_q <= ST_HOLD;
                        mrdN_q  <= 1'b1;
                        mwrN_q  <= 1'b1;
                        if (owner_q == OWN_CPU) begin
                            cpuAck_q <= 1'b1;
                            if (!wr_q) begin
                                cpuRdata_q <= mem_rdata;
                            end
                        end else begin
                            icdAck_q <= 1'b1;
                            if (!wr_q) begin
                                icdRdata_q <= mem_rdata;
                            end
                        end
                    end
                end
                ST_HOLD: begin
                    if (phaseDone) begin
                        state_q   <= ST_IDLE;
                        m1csN_q   <= 1'b1;
                        wdataOe_q <= 1'b0;
                    end
                end
                default: begin
                    state_q <= ST_IDLE;
                end
            endcase
        end
    end

    assign cpu_rdata    = cpuRdata_q;
    assign cpu_ack      = cpuAck_q;
    assign icd_rdata    = icdRdata_q;
    assign icd_ack      = icdAck_q;
    assign mem_addr     = memAddr_q;
    assign mem_wdata    = memWdata_q;
    assign mem_wdata_oe = wdataOe_q;
    assign m1cs_n       = m1csN_q;
    assign mrd_n        = mrdN_q;
    assign mwr_n        = mwrN_q;

endmodule

// File: tb/tb_sram_bus_arbiter.sv
// Bench for sram_bus_arbiter: directed vector table, multi-cycle corner sequences and a
// randomized phase against a transaction-level model of the arbiter with an SRAM model.
module tb_sram_bus_arbiter;

    localparam int ADDR_W     = 21;
    localparam int SETUP_CYC  = 1;
    localparam int STROBE_CYC = 2;
    localparam int HOLD_CYC   = 1;
    localparam int ACCESS_CYC = SETUP_CYC + STROBE_CYC + HOLD_CYC;
    localparam int ACK_CYC    = 1 + SETUP_CYC + STROBE_CYC;

    logic              clk6x = 1'b0;
    logic              resetn;
    logic              cpuReq, cpuWr, cpuAck, cpuSlotSoon;
    logic [ADDR_W-1:0] cpuAddr;
    logic [7:0]        cpuWdata, cpuRdata;
    logic              icdReq, icdWr, icdAck;
    logic [ADDR_W-1:0] icdAddr;
    logic [7:0]        icdWdata, icdRdata;
    logic [ADDR_W-1:0] memAddr;
    logic [7:0]        memWdata, memRdata;
    logic              memWdataOe, m1csN, mrdN, mwrN;

    int compared   = 0;
    int mismatched = 0;
    int cyc        = 0;

    logic [7:0] sram [logic [ADDR_W-1:0]];

    typedef struct {
        bit                isIcd;
        bit                wr;
        bit                dropReq;
        logic [ADDR_W-1:0] addr;
        logic [7:0]        wdata;
        logic [7:0]        expRdata;
    } vector_t;

    vector_t vectors [8];

    always #5 clk6x = ~clk6x;

    sram_bus_arbiter #(
        .ADDR_W(ADDR_W), .SETUP_CYC(SETUP_CYC), .STROBE_CYC(STROBE_CYC), .HOLD_CYC(HOLD_CYC)
    ) dut (
        .clk6x         (clk6x),
        .resetn        (resetn),
        .cpu_req       (cpuReq),
        .cpu_wr        (cpuWr),
        .cpu_addr      (cpuAddr),
        .cpu_wdata     (cpuWdata),
        .cpu_rdata     (cpuRdata),
        .cpu_ack       (cpuAck),
        .cpu_slot_soon (cpuSlotSoon),
        .icd_req       (icdReq),
        .icd_wr        (icdWr),
        .icd_addr      (icdAddr),
        .icd_wdata     (icdWdata),
        .icd_rdata     (icdRdata),
        .icd_ack       (icdAck),
        .mem_addr      (memAddr),
        .mem_wdata     (memWdata),
        .mem_wdata_oe  (memWdataOe),
        .mem_rdata     (memRdata),
        .m1cs_n        (m1csN),
        .mrd_n         (mrdN),
        .mwr_n         (mwrN)
    );

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        compared++;
        if (actual !== expected) begin
            mismatched++;
            $display("[TB] FAIL %s: actual 0x%0h, required 0x%0h (cycle %0d)", name, actual, expected, cyc);
        end
    endtask

    task automatic checkBit(input string name, input logic actual, input logic expected);
        checkOutput(name, 32'(actual), 32'(expected));
    endtask

    // Advance to the middle of the next cycle; the SRAM model acts on the strobes it sees there.
    task automatic nextCycle();
        @(negedge clk6x);
        cyc++;
        if (mwrN === 1'b0) sram[memAddr] = memWdata;
        memRdata = sram.exists(memAddr) ? sram[memAddr] : 8'h00;
    endtask

    task automatic applyStimulus(input bit isIcd, input bit wr, input logic [ADDR_W-1:0] addr,
                                 input logic [7:0] wdata);
        if (isIcd) begin
            icdReq = 1'b1; icdWr = wr; icdAddr = addr; icdWdata = wdata;
        end else begin
            cpuReq = 1'b1; cpuWr = wr; cpuAddr = addr; cpuWdata = wdata;
        end
    endtask

    // Expected pin state t cycles after the grant edge (t outside 1..ACCESS_CYC means bus idle).
    task automatic checkBus(input int t, input bit isIcd, input bit wr, input logic [ADDR_W-1:0] addr,
                            input logic [7:0] wdata, input string tag);
        bit inAccess;
        bit inStrobe;
        inAccess = (t >= 1) && (t <= ACCESS_CYC);
        inStrobe = (t > SETUP_CYC) && (t <= SETUP_CYC + STROBE_CYC);
        checkBit({tag, " m1cs_n"}, m1csN, !inAccess);
        checkBit({tag, " mrd_n"}, mrdN, !(inStrobe && !wr));
        checkBit({tag, " mwr_n"}, mwrN, !(inStrobe && wr));
        checkBit({tag, " mem_wdata_oe"}, memWdataOe, inAccess && wr);
        checkBit({tag, " cpu_ack"}, cpuAck, (t == ACK_CYC) && !isIcd);
        checkBit({tag, " icd_ack"}, icdAck, (t == ACK_CYC) && isIcd);
        if (inAccess) begin
            checkOutput({tag, " mem_addr"}, 32'(memAddr), 32'(addr));
            if (wr) checkOutput({tag, " mem_wdata"}, 32'(memWdata), 32'(wdata));
        end
    endtask

    task automatic runVector(input vector_t v, input int idx);
        string tag;
        tag = $sformatf("vec%0d", idx);
        applyStimulus(v.isIcd, v.wr, v.addr, v.wdata);
        for (int t = 1; t <= ACCESS_CYC + 1; t++) begin
            nextCycle();
            if (t == 1) begin
                if (v.isIcd) begin
                    icdAddr = ~v.addr; icdWdata = ~v.wdata; icdWr = ~v.wr;
                    if (v.dropReq) icdReq = 1'b0;
                end else begin
                    cpuAddr = ~v.addr; cpuWdata = ~v.wdata; cpuWr = ~v.wr;
                    if (v.dropReq) cpuReq = 1'b0;
                end
            end
            checkBus(t, v.isIcd, v.wr, v.addr, v.wdata, tag);
            if (t == ACK_CYC) begin
                if (!v.wr) begin
                    checkOutput({tag, " rdata"}, 32'(v.isIcd ? icdRdata : cpuRdata), 32'(v.expRdata));
                end
                if (v.isIcd) icdReq = 1'b0; else cpuReq = 1'b0;
            end
        end
    endtask

    task automatic waitAck(input bit isIcd, input int budget, output int ackCyc);
        bit found;
        found  = 1'b0;
        ackCyc = -1;
        for (int k = 0; k < budget && !found; k++) begin
            nextCycle();
            if ((isIcd ? icdAck : cpuAck) === 1'b1) begin
                found  = 1'b1;
                ackCyc = cyc;
            end
        end
        checkBit("ack within budget", found, 1'b1);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, actual running, required finished");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int c0, ack1, ack2;
        int freeAt, grantCyc, t;
        bit active, aIcd, aWr, cpuPending, icdPending;
        logic [ADDR_W-1:0] aAddr;
        logic [7:0] aWdata, rd, expCpuRd, expIcdRd;
        logic [7:0] refMem [logic [ADDR_W-1:0]];

        vectors[0] = '{1'b0, 1'b1, 1'b0, 21'h00010, 8'h12, 8'h00};
        vectors[1] = '{1'b0, 1'b0, 1'b0, 21'h00010, 8'h00, 8'h12};
        vectors[2] = '{1'b0, 1'b1, 1'b0, 21'h00011, 8'h34, 8'h00};
        vectors[3] = '{1'b0, 1'b1, 1'b1, 21'h00012, 8'h56, 8'h00};
        vectors[4] = '{1'b1, 1'b1, 1'b0, 21'h1F000, 8'hA5, 8'h00};
        vectors[5] = '{1'b1, 1'b0, 1'b0, 21'h1F000, 8'h00, 8'hA5};
        vectors[6] = '{1'b1, 1'b0, 1'b0, 21'h00012, 8'h00, 8'h56};
        vectors[7] = '{1'b0, 1'b0, 1'b1, 21'h00011, 8'h00, 8'h34};

        resetn = 1'b0;
        cpuReq = 1'b0; cpuWr = 1'b0; cpuAddr = '0; cpuWdata = '0; cpuSlotSoon = 1'b0;
        icdReq = 1'b0; icdWr = 1'b0; icdAddr = '0; icdWdata = '0;
        memRdata = 8'h00;
        repeat (3) nextCycle();

        checkBit("reset m1cs_n", m1csN, 1'b1);
        checkBit("reset mrd_n", mrdN, 1'b1);
        checkBit("reset mwr_n", mwrN, 1'b1);
        checkBit("reset mem_wdata_oe", memWdataOe, 1'b0);
        checkBit("reset cpu_ack", cpuAck, 1'b0);
        checkBit("reset icd_ack", icdAck, 1'b0);
        checkOutput("reset cpu_rdata", 32'(cpuRdata), 32'h0);
        checkOutput("reset icd_rdata", 32'(icdRdata), 32'h0);
        checkOutput("reset mem_addr", 32'(memAddr), 32'h0);
        checkOutput("reset mem_wdata", 32'(memWdata), 32'h0);

        resetn = 1'b1;
        nextCycle();

        for (int i = 0; i < 8; i++) runVector(vectors[i], i);
        checkOutput("sram holds 0x00010", 32'(sram[21'h00010]), 32'h12);

        $display("[TB] simultaneous CPU and ICD requests");
        applyStimulus(1'b0, 1'b0, 21'h00010, 8'h00);
        applyStimulus(1'b1, 1'b0, 21'h1F000, 8'h00);
        for (int k = 1; k <= ACCESS_CYC + 1; k++) begin
            nextCycle();
            checkBus(k, 1'b0, 1'b0, 21'h00010, 8'h00, "arb cpu");
            if (k == ACK_CYC) begin
                checkOutput("arb cpu_rdata", 32'(cpuRdata), 32'h12);
                cpuReq = 1'b0;
            end
        end
        for (int k = 1; k <= ACCESS_CYC + 1; k++) begin
            nextCycle();
            checkBus(k, 1'b1, 1'b0, 21'h1F000, 8'h00, "arb icd");
            if (k == ACK_CYC) begin
                checkOutput("arb icd_rdata", 32'(icdRdata), 32'hA5);
                icdReq = 1'b0;
            end
        end

        $display("[TB] ICD held off by cpu_slot_soon");
        cpuSlotSoon = 1'b1;
        applyStimulus(1'b1, 1'b0, 21'h00010, 8'h00);
        for (int k = 1; k <= 10; k++) begin
            nextCycle();
            checkBit("slot_soon m1cs_n", m1csN, 1'b1);
            checkBit("slot_soon icd_ack", icdAck, 1'b0);
        end
        cpuSlotSoon = 1'b0;
        for (int k = 1; k <= ACCESS_CYC + 1; k++) begin
            nextCycle();
            checkBus(k, 1'b1, 1'b0, 21'h00010, 8'h00, "slot icd");
            if (k == ACK_CYC) begin
                checkOutput("slot icd_rdata", 32'(icdRdata), 32'h12);
                icdReq = 1'b0;
            end
        end

        $display("[TB] reset during write strobe");
        applyStimulus(1'b0, 1'b1, 21'h00555, 8'h77);
        nextCycle();
        nextCycle();
        checkBit("pre-reset mwr_n", mwrN, 1'b0);
        #2;
        resetn = 1'b0;
        cpuReq = 1'b0;
        #1;
        checkBit("async reset mwr_n", mwrN, 1'b1);
        checkBit("async reset m1cs_n", m1csN, 1'b1);
        checkBit("async reset mem_wdata_oe", memWdataOe, 1'b0);
        #1;
        resetn = 1'b1;
        for (int k = 0; k < 3; k++) begin
            nextCycle();
            checkBit("post-reset m1cs_n", m1csN, 1'b1);
            checkBit("post-reset cpu_ack", cpuAck, 1'b0);
        end
        checkOutput("post-reset cpu_rdata", 32'(cpuRdata), 32'h0);
        runVector(vectors[1], 8);

        $display("[TB] back-to-back CPU reads");
        applyStimulus(1'b0, 1'b0, 21'h00011, 8'h00);
        c0 = cyc;
        waitAck(1'b0, 20, ack1);
        checkOutput("b2b first ack latency", 32'(ack1 - c0), 32'(ACK_CYC));
        checkOutput("b2b first cpu_rdata", 32'(cpuRdata), 32'h34);
        cpuReq = 1'b0;
        nextCycle();
        nextCycle();
        applyStimulus(1'b0, 1'b0, 21'h00012, 8'h00);
        waitAck(1'b0, 20, ack2);
        checkOutput("b2b ack spacing", 32'(ack2 - ack1), 32'd6);
        checkOutput("b2b second cpu_rdata", 32'(cpuRdata), 32'h56);
        cpuReq = 1'b0;

        $display("[TB] randomized traffic");
        nextCycle();
        resetn = 1'b0;
        nextCycle();
        resetn = 1'b1;
        active = 1'b0; cpuPending = 1'b0; icdPending = 1'b0;
        aIcd = 1'b0; aWr = 1'b0; aAddr = '0; aWdata = '0;
        grantCyc = 0; freeAt = cyc;
        expCpuRd = 8'h00; expIcdRd = 8'h00;
        for (int n = 0; n < 600; n++) begin
            nextCycle();
            t = active ? (cyc - grantCyc) : 0;
            checkBus(t, aIcd, aWr, aAddr, aWdata, "rand");
            if (active && t == ACK_CYC) begin
                if (aWr) begin
                    refMem[aAddr] = aWdata;
                end else begin
                    rd = refMem.exists(aAddr) ? refMem[aAddr] : 8'h00;
                    if (aIcd) expIcdRd = rd; else expCpuRd = rd;
                end
                if (aIcd) begin icdPending = 1'b0; icdReq = 1'b0; end
                else begin cpuPending = 1'b0; cpuReq = 1'b0; end
            end
            checkOutput("rand cpu_rdata", 32'(cpuRdata), 32'(expCpuRd));
            checkOutput("rand icd_rdata", 32'(icdRdata), 32'(expIcdRd));
            if (active && t == ACCESS_CYC) active = 1'b0;

            if (active && !aIcd && cpuPending) begin
                cpuAddr = 21'h0A000 + 21'($urandom_range(15)); cpuWdata = 8'($urandom);
                cpuWr = 1'($urandom_range(1));
            end
            if (active && aIcd && icdPending) begin
                icdAddr = 21'h0A000 + 21'($urandom_range(15)); icdWdata = 8'($urandom);
                icdWr = 1'($urandom_range(1));
            end
            if (!cpuPending && $urandom_range(2) == 0) begin
                cpuPending = 1'b1;
                applyStimulus(1'b0, 1'($urandom_range(1)), 21'h0A000 + 21'($urandom_range(15)), 8'($urandom));
            end
            if (!icdPending && $urandom_range(1) == 0) begin
                icdPending = 1'b1;
                applyStimulus(1'b1, 1'($urandom_range(1)), 21'h0A000 + 21'($urandom_range(15)), 8'($urandom));
            end
            cpuSlotSoon = ($urandom_range(3) == 0);

            if (!active && cyc >= freeAt) begin
                if (cpuReq) begin
                    active = 1'b1; aIcd = 1'b0; aWr = cpuWr; aAddr = cpuAddr; aWdata = cpuWdata;
                end else if (icdReq && !cpuSlotSoon) begin
                    active = 1'b1; aIcd = 1'b1; aWr = icdWr; aAddr = icdAddr; aWdata = icdWdata;
                end
                if (active) begin
                    grantCyc = cyc;
                    freeAt   = cyc + ACCESS_CYC + 1;
                end
            end
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

endmodule
